// File: rtl/fsm_control.sv
// fsm_control: multicycle control unit for the 16-bit CR16-subset datapath.
// Steps through FETCH -> LOADIR -> EXEC (-> LDWB for loads) and drives every
// datapath enable and mux select. All outputs are combinational from the
// current state, the registered opcode and the condition result.
//
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   Opcode[7:0]   - {IR[15:12], IR[7:4]} from the instruction register
//   cond_true     - branch/jump condition satisfied by the current flags
//   ir_en, pc_en  - IR load / PC write enables
//   pc_sel[1:0]   - 0: PC+1, 1: PC+disp, 2: Rsrc
//   addr_sel      - memory address: 0: PC, 1: Rsrc
//   reg_wr_en     - register file write to Rdst
//   mem_wr_en     - data memory write
//   wb_sel[1:0]   - write-back: 0: ALU, 1: memory, 2: PC (link)
//   alu_src_imm   - ALU B operand: 0: Rsrc, 1: immediate
//   flags_en      - PSR flag update
//   instr_done    - high in the last cycle of each instruction
//   state[1:0]    - current state (debug)
//
// state  | meaning
// FETCH  | memory addressed by PC
// LOADIR | instruction word valid; IR loads and PC increments on exit
// EXEC   | decode and execute; final cycle for all but LOAD
// LDWB   | load write-back from memory read data

module fsm_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Opcode,
  input  logic       cond_true,
  output logic       ir_en,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       addr_sel,
  output logic       reg_wr_en,
  output logic       mem_wr_en,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic       flags_en,
  output logic       instr_done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    LOADIR = 2'd1,
    EXEC   = 2'd2,
    LDWB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0] hi, ext;
  assign hi  = Opcode[7:4];
  assign ext = Opcode[3:0];

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = FETCH;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 2'd0;
    addr_sel    = 1'b0;
    reg_wr_en   = 1'b0;
    mem_wr_en   = 1'b0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    flags_en    = 1'b0;
    instr_done  = 1'b0;

    // Reset wins over everything: outputs stay at their zero defaults.
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          state_d = LOADIR;
        end
        LOADIR: begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = EXEC;
        end
        EXEC: begin
          instr_done = 1'b1;
          state_d    = FETCH;
          case (hi)
            4'b0000: begin
              if (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
                reg_wr_en = (ext != 4'hB);
                flags_en  = (ext inside {4'h5, 4'h9, 4'hB});
              end
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b1001, 4'b1011, 4'b1101: begin
              alu_src_imm = 1'b1;
              reg_wr_en   = (hi != 4'hB);
              flags_en    = (hi inside {4'h5, 4'h9, 4'hB});
            end
            4'b1111: begin
              // LUI: immediate write, no flag update
              alu_src_imm = 1'b1;
              reg_wr_en   = 1'b1;
            end
            4'b1000: begin
              if (ext == 4'h4) begin
                reg_wr_en = 1'b1;
              end else if (ext == 4'h0 || ext == 4'h1) begin
                reg_wr_en   = 1'b1;
                alu_src_imm = 1'b1;
              end
            end
            4'b0100: begin
              case (ext)
                4'h0: begin
                  addr_sel   = 1'b1;
                  instr_done = 1'b0;
                  state_d    = LDWB;
                end
                4'h4: begin
                  addr_sel  = 1'b1;
                  mem_wr_en = 1'b1;
                end
                4'hC: begin
                  pc_sel = 2'd2;
                  pc_en  = cond_true;
                end
                4'h8: begin
                  // Link value is the PC already incremented in LOADIR.
                  reg_wr_en = 1'b1;
                  wb_sel    = 2'd2;
                  pc_en     = 1'b1;
                  pc_sel    = 2'd2;
                end
                default: ;
              endcase
            end
            4'b1100: begin
              pc_sel = 2'd1;
              pc_en  = cond_true;
            end
            default: ;
          endcase
        end
        LDWB: begin
          reg_wr_en  = 1'b1;
          wb_sel     = 2'd1;
          addr_sel   = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_control.sv
// Bench for fsm_control: expected output vectors are queued as each cycle's
// stimulus is driven and compared on the following falling edge.

module tb_fsm_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Opcode;
  logic       cond_true;
  logic       ir_en, pc_en, addr_sel, reg_wr_en, mem_wr_en;
  logic       alu_src_imm, flags_en, instr_done;
  logic [1:0] pc_sel, wb_sel, state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  fsm_control dut (
    .clk         (clk),
    .rst         (rst),
    .Opcode      (Opcode),
    .cond_true   (cond_true),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .addr_sel    (addr_sel),
    .reg_wr_en   (reg_wr_en),
    .mem_wr_en   (mem_wr_en),
    .wb_sel      (wb_sel),
    .alu_src_imm (alu_src_imm),
    .flags_en    (flags_en),
    .instr_done  (instr_done),
    .state       (state)
  );

  always #5 clk = ~clk;

  // vector layout: {state, ir, pc_en, pc_sel, addr_sel, reg_wr, mem_wr, wb_sel, imm, flags, done}
  function automatic logic [13:0] ev(input logic [1:0] st, input logic ir, input logic pc,
                                     input logic [1:0] ps, input logic as, input logic rw,
                                     input logic mw, input logic [1:0] wb, input logic im,
                                     input logic fl, input logic dn);
    return {st, ir, pc, ps, as, rw, mw, wb, im, fl, dn};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (st|ir|pc|psel|as|rw|mw|wb|imm|fl|dn)", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_item_t it;
      it = sb_q.pop_front();
      check(it.tag, {state, ir_en, pc_en, pc_sel, addr_sel, reg_wr_en, mem_wr_en,
                     wb_sel, alu_src_imm, flags_en, instr_done}, it.exp);
    end
  end

  task automatic tick(input string tag, input logic r, input logic [7:0] op,
                      input logic c, input logic [13:0] e);
    rst       = r;
    Opcode    = op;
    cond_true = c;
    sb_q.push_back('{tag, e});
    @(posedge clk);
    #1;
  endtask

  task automatic front(input string tag, input logic [7:0] op, input logic c);
    tick({tag, "_fetch"},  1'b0, op, c, ev(2'd0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0));
    tick({tag, "_loadir"}, 1'b0, op, c, ev(2'd1, 1, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0));
  endtask

  task automatic instr(input string tag, input logic [7:0] op, input logic c,
                       input logic [13:0] e_exec);
    front(tag, op, c);
    tick({tag, "_exec"}, 1'b0, op, c, e_exec);
  endtask

  localparam logic [13:0] ZERO = 14'd0;

  initial begin
    rst = 1'b1; Opcode = 8'h00; cond_true = 1'b0;
    @(posedge clk);
    #1;
    tick("reset0", 1'b1, 8'h05, 1'b1, ZERO);
    tick("reset1", 1'b1, 8'h05, 1'b1, ZERO);

    //                          st    ir pc ps    as rw mw wb    im fl dn
    instr("add",  8'h05, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 1));
    instr("add_c", 8'h05, 1'b1, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 1));
    instr("and",  8'h01, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 1));
    instr("sub",  8'h09, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 1));
    instr("cmp",  8'h0B, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 1));
    instr("mov",  8'h0D, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 1));
    instr("cmpi", 8'hB0, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 1, 1));
    instr("addi", 8'h57, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 1, 1, 1));
    instr("andi", 8'h10, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 1, 0, 1));
    instr("lsh",  8'h84, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 1));
    instr("lshi", 8'h81, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 1, 0, 1));
    instr("shnop", 8'h86, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1));
    instr("rnop", 8'h0F, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1));
    instr("nop7", 8'h70, 1'b1, ev(2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1));

    instr("load", 8'h40, 1'b0, ev(2'd2, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0));
    tick("load_wb", 1'b0, 8'h40, 1'b0, ev(2'd3, 0, 0, 2'd0, 1, 1, 0, 2'd1, 0, 0, 1));
    instr("after_load", 8'h05, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 1));

    instr("stor", 8'h44, 1'b0, ev(2'd2, 0, 0, 2'd0, 1, 0, 1, 2'd0, 0, 0, 1));
    instr("bc_t", 8'hC0, 1'b1, ev(2'd2, 0, 1, 2'd1, 0, 0, 0, 2'd0, 0, 0, 1));
    instr("bc_f", 8'hC0, 1'b0, ev(2'd2, 0, 0, 2'd1, 0, 0, 0, 2'd0, 0, 0, 1));
    instr("jc_t", 8'h4C, 1'b1, ev(2'd2, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 0, 1));
    instr("jc_f", 8'h4C, 1'b0, ev(2'd2, 0, 0, 2'd2, 0, 0, 0, 2'd0, 0, 0, 1));
    instr("jal",  8'h48, 1'b0, ev(2'd2, 0, 1, 2'd2, 0, 1, 0, 2'd2, 0, 0, 1));

    // reset during EXEC of STOR: outputs zero, state still reports EXEC
    front("stor_abort", 8'h44, 1'b0);
    tick("stor_abort_exec", 1'b1, 8'h44, 1'b0, ev(2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0));
    instr("post_abort", 8'h44, 1'b0, ev(2'd2, 0, 0, 2'd0, 1, 0, 1, 2'd0, 0, 0, 1));

    // reset during LOADIR suppresses ir_en/pc_en
    tick("ldir_abort_fetch", 1'b0, 8'h05, 1'b0, ZERO);
    tick("ldir_abort", 1'b1, 8'h05, 1'b0, ev(2'd1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0));

    // reset during LDWB
    instr("load2", 8'h40, 1'b0, ev(2'd2, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0));
    tick("ldwb_abort", 1'b1, 8'h40, 1'b0, ev(2'd3, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0));
    instr("final", 8'h48, 1'b0, ev(2'd2, 0, 1, 2'd2, 0, 1, 0, 2'd2, 0, 0, 1));

    @(negedge clk);
    if (sb_q.size() != 0)
      check("sb_drain", 14'(sb_q.size()), ZERO);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_control.md
# fsm_control

Multicycle control unit that sequences the instruction register, PC, register file, ALU and memory port of the 16-bit CR16-subset datapath. It consumes the registered opcode field from the instruction register (`{IR[15:12], IR[7:4]}`) and a condition result from the flag/condition checker. It drives every enable and mux select in the datapath, one state per cycle.

## Interface
- Parameters: none. State encodings are fixed: FETCH=0, LOADIR=1, EXEC=2, LDWB=3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Opcode` in 8: `{IR[15:12], IR[7:4]}`, the registered IR output. It is stable from EXEC onward.
- `cond_true` in 1: the condition in IR[11:8] is satisfied by the current flags.
- `ir_en` out 1: IR load enable.
- `pc_en` out 1: PC write enable.
- `pc_sel` out 2: PC source. 0 selects PC+1, 1 selects PC+disp (branch), 2 selects Rsrc (jump).
- `addr_sel` out 1: memory address source. 0 selects PC, 1 selects Rsrc register.
- `reg_wr_en` out 1: register file write to Rdst.
- `mem_wr_en` out 1: data memory write (store Rdst to addr).
- `wb_sel` out 2: write-back source. 0 selects ALU, 1 selects memory read data, 2 selects PC (link).
- `alu_src_imm` out 1: ALU B operand. 0 selects Rsrc, 1 selects immediate.
- `flags_en` out 1: PSR flag register update.
- `instr_done` out 1: pulses in the final cycle of each instruction.
- `state` out 2: current state, for debug and testbench use.

## Operation
- All outputs are combinational from (state, Opcode, cond_true). Any output not listed for a state is 0.
- FETCH: addr_sel=0. Next state is LOADIR.
- LOADIR: ir_en=1, pc_en=1, pc_sel=0. Memory data for the old PC is valid in this cycle. Next state is EXEC.
- EXEC: behaviour is decoded from `hi=Opcode[7:4]` and `ext=Opcode[3:0]`:
  - hi=0000, R-type. ext ∈ {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV}.
    - All: alu_src_imm=0, wb_sel=0.
    - reg_wr_en=1 for all except CMP.
    - flags_en=1 for ADD, SUB and CMP.
  - hi ∈ {0001, 0010, 0011, 0101, 1001, 1011, 1101, 1111}, immediate forms.
    - Same rules as R-type, with alu_src_imm=1.
    - CMPI (1011) sets no reg_wr_en.
    - 1111 (LUI) sets reg_wr_en only.
  - hi=1000, shift.
    - ext=0100: register form, reg_wr_en=1, alu_src_imm=0.
    - ext ∈ {0000, 0001}: immediate form, reg_wr_en=1, alu_src_imm=1.
  - hi=0100, ext=0000 (LOAD): addr_sel=1. Next state is LDWB.
  - hi=0100, ext=0100 (STOR): addr_sel=1, mem_wr_en=1.
  - hi=0100, ext=1100 (Jcond): pc_sel=2, and pc_en=cond_true.
  - hi=0100, ext=1000 (JAL): reg_wr_en=1, wb_sel=2 (link = already-incremented PC), pc_en=1, pc_sel=2.
  - hi=1100 (Bcond): pc_sel=1, and pc_en=cond_true.
  - Any other opcode is a NOP: no enables asserted.
  - instr_done=1 in EXEC for every class except LOAD. Next state is FETCH, except for LOAD.
- LDWB: reg_wr_en=1, wb_sel=1, addr_sel=1 (address held), instr_done=1. Next state is FETCH.
- The state register is the only sequential element.

## Timing
- Reset: while rst=1 at a rising edge, state becomes FETCH.
  - Outputs are forced to 0 in any cycle where rst=1, whatever the state.
  - After release, the first instruction begins with FETCH on the next cycle.
- Reset mid-instruction (in LOADIR, EXEC or LDWB) aborts the instruction. No ir_en, pc_en, reg_wr_en or mem_wr_en is asserted in the reset cycle.
- Instruction latency, counted from FETCH:
  - ALU, shift, STOR, branch, jump, JAL and NOP: 3 cycles.
  - LOAD: 4 cycles.
- IR captures on the LOADIR→EXEC edge. The PC increments on the same edge.
- Branch and jump targets are written on the EXEC→FETCH edge. The following FETCH uses the new PC.
- Untaken Bcond/Jcond: pc_en=0 in EXEC. The next FETCH uses PC+1.
- cond_true is sampled only in EXEC for hi=1100 and for hi=0100 with ext=1100. It is ignored elsewhere.

## Test plan
- Reset: rst=1 for 2 cycles, then 0.
  - state=0 and all outputs 0 during reset.
  - Expected sequence: FETCH, LOADIR with ir_en=1 and pc_en=1, then EXEC.
- ADD (Opcode=0x05): in EXEC, reg_wr_en=1, flags_en=1, alu_src_imm=0, instr_done=1. Then back to FETCH after 3 cycles.
- CMPI (Opcode=0xB0): in EXEC, flags_en=1, alu_src_imm=1, reg_wr_en=0.
- LOAD (Opcode=0x40):
  - EXEC: addr_sel=1, reg_wr_en=0.
  - LDWB: reg_wr_en=1, wb_sel=1, instr_done=1.
  - Total 4 cycles.
- Bcond (Opcode=0xC0):
  - cond_true=1 gives pc_en=1, pc_sel=1 in EXEC.
  - A repeat with cond_true=0 gives pc_en=0.
- JAL (Opcode=0x48): in EXEC, reg_wr_en=1, wb_sel=2, pc_en=1, pc_sel=2.
- Reset mid-operation: assert rst during the EXEC cycle of STOR (0x44).
  - mem_wr_en=0 in that cycle.
  - state=FETCH on the next cycle.
